clint: RTL
==========

# clint

Core-local interrupt/exception sequencer that takes machine-mode traps into the core and drives `ctrl`'s `clint_hold_flag` input.
- Detects `ecall`, `ebreak` and `mret` in ID and level external interrupts gated by `mstatus.MIE`.
- Freezes IF/ID through `ctrl` while it writes mepc/mstatus/mcause over a dedicated CSR write port.
- Issues a one-cycle redirect to ex (`int_assert_o`/`int_addr_o`).

## Interface
- `INT_W`, default 8: number of external interrupt request lines.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `int_flag_i`  in  INT_W  level interrupt requests; any bit set = async request.
- `inst_i`  in  32  instruction currently in ID.
- `inst_addr_i`  in  32  PC of `inst_i`.
- `jump_flag_i`  in  1  ex jump this cycle.
- `jump_addr_i`  in  32  ex jump target.
- `div_started_i`  in  1  ex divider busy.
- `csr_mtvec_i`  in  32  current CSR value.
- `csr_mepc_i`  in  32  current CSR value.
- `csr_mstatus_i`  in  32  current CSR value.
- `global_int_en_i`  in  1  `mstatus.MIE`.
- `hold_flag_o`  out  1  `HoldEnable` while sequencing; goes to `ctrl`.
- `we_o`  out  1  CSR write enable.
- `waddr_o`  out  12  CSR write address.
- `data_o`  out  32  CSR write data.
- `int_assert_o`  out  1  one-cycle redirect strobe to ex.
- `int_addr_o`  out  32  redirect target.

## Operation
- Request decode, evaluated only in IDLE, priority highest first:
  - SYNC: `inst_i` = 32'h00000073 (ecall, cause 11) or 32'h00100073 (ebreak, cause 3).
  - ASYNC: `|int_flag_i` and `global_int_en_i`; cause 32'h8000000B.
  - MRET: `inst_i` = 32'h30200073.
- SYNC and ASYNC are deferred while `div_started_i` is high: stay IDLE, no hold.
- Return address (epc):
  - SYNC: `inst_addr_i`.
  - ASYNC: `jump_addr_i` if `jump_flag_i`, else `inst_addr_i`.
  - epc and cause are latched on the detection cycle.
- FSM states and transitions:
  - IDLE → W_MEPC on SYNC/ASYNC.
  - IDLE → W_MRET on MRET.
  - W_MEPC → W_MSTATUS → W_MCAUSE → IDLE.
  - W_MRET → IDLE.
- CSR writes:
  - W_MEPC: addr 12'h341, data epc.
  - W_MSTATUS: addr 12'h300, data = mstatus with bit7 (MPIE) ← bit3, bit3 (MIE) ← 0.
  - W_MCAUSE: addr 12'h342, data cause.
  - W_MRET: addr 12'h300, data = mstatus with bit3 ← bit7, bit7 ← 1.
- Redirect: on leaving W_MCAUSE, `int_addr_o` = `csr_mtvec_i`; on leaving W_MRET, `int_addr_o` = `csr_mepc_i`.
- Requests arriving outside IDLE are ignored. A still-asserted level interrupt is re-evaluated in IDLE and is masked by the cleared MIE.
- `int_flag_i` is level, not latched: if it drops before IDLE it is not taken.

## Timing
- Detection cycle T:
  - `hold_flag_o` is combinational high in T.
  - From T+1 it stays high for every non-IDLE state.
- SYNC/ASYNC:
  - `we_o` high T+1 (mepc), T+2 (mstatus), T+3 (mcause).
  - `int_assert_o` high T+4 only; `hold_flag_o` low in T+4.
- MRET:
  - `we_o` high T+1.
  - `int_assert_o` high T+2 only.
- `we_o`, `waddr_o`, `data_o`, `int_assert_o` and `int_addr_o` are registered.
- `int_addr_o` holds its last value; it is valid only while `int_assert_o` is high.
- Reset, including mid-sequence: next edge forces IDLE, with `hold_flag_o`, `we_o`, `int_assert_o` = 0, `waddr_o` = 0 and `data_o`, `int_addr_o` = `InstAddrNop`/0. No partial CSR write is completed.
- Back-to-back: a new request may be detected in the same cycle `int_assert_o` is high.

## Structure
- `defines.v` holds:
  - CSR addresses for mepc, mstatus and mcause.
  - ecall, ebreak and mret encodings.
  - cause codes.
  - FSM state encodings.
  - existing `HoldEnable`/`WriteEnable`/`InstAddrNop` macros.
- Flat module; no sub-module is warranted.

## Test plan
- ecall at PC 0x100, mstatus 0x8, mtvec 0x400:
  - writes (341, 0x100), (300, 0x80), (342, 11) on T+1..T+3.
  - `int_assert_o` at T+4 with addr 0x400.
  - hold high T..T+3.
- `int_flag_i`=0x01, MIE=1, `jump_flag_i`=1, `jump_addr_i`=0x220 → mepc write 0x220, mcause 0x8000000B.
- mret with mstatus 0x80, mepc 0x104 → write (300, 0x88) at T+1, assert to 0x104 at T+2.
- ecall while `div_started_i`=1 for 5 cycles → no hold and no writes until div drops, then the normal sequence.
- `int_flag_i` set with MIE=0 → no activity. ebreak and interrupt simultaneously → cause 3 taken.
- `rst` pulsed in W_MSTATUS → IDLE next edge, no mcause write, no `int_assert_o`.

Source files
------------

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt sequencer: CSR addresses,
// SYSTEM instruction encodings, trap cause codes and FSM state encodings.
package clint_pkg;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  localparam logic        HOLD_ENABLE   = 1'b1;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic [31:0] INST_ADDR_NOP = 32'h0000_0000;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_W_MEPC    = 3'd1;
  localparam state_t S_W_MSTATUS = 3'd2;
  localparam state_t S_W_MCAUSE  = 3'd3;
  localparam state_t S_W_MRET    = 3'd4;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] ms);
    return {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]};
  endfunction

  // Trap return: MIE restored from MPIE, MPIE set.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] ms);
    return {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]};
  endfunction

endpackage

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer. Detects ecall/ebreak/mret in ID
// and gated external interrupts, holds the front end while it writes
// mepc/mstatus/mcause, then issues a one-cycle redirect to ex.
//
//   state       | meaning
//   ------------+----------------------------------------------
//   S_IDLE      | watching ID and interrupt lines for a request
//   S_W_MEPC    | mepc write on the CSR port
//   S_W_MSTATUS | mstatus write (MPIE <- MIE, MIE <- 0)
//   S_W_MCAUSE  | mcause write; redirect to mtvec on exit
//   S_W_MRET    | mstatus restore; redirect to mepc on exit
module clint
  import clint_pkg::*;
#(
  parameter int INT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [31:0]       jump_addr_i,
  input  logic              div_started_i,
  input  logic [31:0]       csr_mtvec_i,
  input  logic [31:0]       csr_mepc_i,
  input  logic [31:0]       csr_mstatus_i,
  input  logic              global_int_en_i,
  output logic              hold_flag_o,
  output logic              we_o,
  output logic [11:0]       waddr_o,
  output logic [31:0]       data_o,
  output logic              int_assert_o,
  output logic [31:0]       int_addr_o
);

  state_t      state;
  state_t      state_next;
  logic [31:0] cause;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_sync;
  logic        is_async;
  logic        is_mret;
  logic        take_trap;
  logic        take_mret;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;

  // Request decode and priority; only acted on while idle. A pending
  // sync/async request (even deferred by the divider) blocks mret.
  always_comb begin
    is_ecall   = (inst_i == INST_ECALL);
    is_ebreak  = (inst_i == INST_EBREAK);
    is_sync    = is_ecall || is_ebreak;
    is_async   = (|int_flag_i) && global_int_en_i;
    is_mret    = (inst_i == INST_MRET);
    take_trap  = (state == S_IDLE) && (is_sync || is_async) && !div_started_i;
    take_mret  = (state == S_IDLE) && is_mret && !is_sync && !is_async;
    trap_cause = is_sync ? (is_ecall ? CAUSE_ECALL : CAUSE_EBREAK) : CAUSE_EXT_INT;
    trap_epc   = (!is_sync && jump_flag_i) ? jump_addr_i : inst_addr_i;
  end

  // Hold is combinational on the detection cycle, then follows the state.
  always_comb begin
    hold_flag_o = ((state != S_IDLE) || take_trap || take_mret) ? HOLD_ENABLE : ~HOLD_ENABLE;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (take_trap)      state_next = S_W_MEPC;
        else if (take_mret) state_next = S_W_MRET;
      end
      S_W_MEPC:    state_next = S_W_MSTATUS;
      S_W_MSTATUS: state_next = S_W_MCAUSE;
      S_W_MCAUSE:  state_next = S_IDLE;
      S_W_MRET:    state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // State register and cause capture on the detection cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cause <= 32'h0;
    end else begin
      state <= state_next;
      if (take_trap) cause <= trap_cause;
    end
  end

  // Registered CSR write port and redirect strobe. The write for each state
  // is launched on the edge that enters it, so epc goes straight from the
  // detection-cycle mux into the mepc write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_o         <= 1'b0;
      waddr_o      <= 12'h0;
      data_o       <= INST_ADDR_NOP;
      int_assert_o <= 1'b0;
      int_addr_o   <= INST_ADDR_NOP;
    end else begin
      we_o         <= 1'b0;
      waddr_o      <= 12'h0;
      data_o       <= 32'h0;
      int_assert_o <= 1'b0;
      if (take_trap) begin
        we_o    <= WRITE_ENABLE;
        waddr_o <= CSR_MEPC;
        data_o  <= trap_epc;
      end else if (take_mret) begin
        we_o    <= WRITE_ENABLE;
        waddr_o <= CSR_MSTATUS;
        data_o  <= mstatus_mret(csr_mstatus_i);
      end else begin
        case (state)
          S_W_MEPC: begin
            we_o    <= WRITE_ENABLE;
            waddr_o <= CSR_MSTATUS;
            data_o  <= mstatus_trap(csr_mstatus_i);
          end
          S_W_MSTATUS: begin
            we_o    <= WRITE_ENABLE;
            waddr_o <= CSR_MCAUSE;
            data_o  <= cause;
          end
          S_W_MCAUSE: begin
            int_assert_o <= 1'b1;
            int_addr_o   <= csr_mtvec_i;
          end
          S_W_MRET: begin
            int_assert_o <= 1'b1;
            int_addr_o   <= csr_mepc_i;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
